ddr3_traffic_checker: RTL and testbench

- Self-checking traffic source upstream of ddr3_memory_controller; replaces the free-running address/data counter in the board-level test top.
- Writes NUM_WORDS words with an address-derived pattern, reads them back, compares each word, and reports pass/fail and error count to LEDs and the ILA.
- Pattern is recomputed at compare time, so no storage is required.

---
 rtl/ddr3_traffic_checker.sv | 150 +++++++++++++++
 tb/tb_ddr3_traffic_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_traffic_checker.sv
// ddr3_traffic_checker
// Self-checking traffic source for the DDR3 controller board test. Writes
// NUM_WORDS words carrying an address-derived pattern, reads them back one
// at a time and compares each word. The expected word is recomputed from
// the word index at compare time, so no data storage is needed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_WRITE   | write_enable high, one word per accepted cycle
// S_READ    | read_enable high for word k
// S_WAIT    | read accepted, waiting for o_user_data_valid or timeout
// S_DONE    | pass finished, results held until next start or reset
module ddr3_traffic_checker #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int NUM_WORDS             = 256,
    parameter logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] START_ADDRESS = '0,
    parameter logic [DQ_BITWIDTH-1:0] DATA_SEED = 16'hA5C3,
    parameter int READ_TIMEOUT          = 1023
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic                                            ctrl_ready,
    output logic                                            write_enable,
    output logic                                            read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                          i_user_data,
    input  logic [DQ_BITWIDTH-1:0]                          o_user_data,
    input  logic                                            o_user_data_valid,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            pass,
    output logic                                            timeout,
    output logic [15:0]                                     error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int TW = (READ_TIMEOUT < 1) ? 1 : $clog2(READ_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_K = AW'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(READ_TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             state;
    logic [AW-1:0]          k;
    logic [TW-1:0]          tmo_cnt;
    logic [AW-1:0]          cur_addr;
    logic [DQ_BITWIDTH-1:0] cur_data;
    logic                   last_word;
    logic                   mismatch;

    // Pattern for the current word index; the address wraps at the address width.
    assign cur_addr  = START_ADDRESS + k;
    assign cur_data  = DATA_SEED ^ DQ_BITWIDTH'(k);
    assign last_word = (k == LAST_K);
    assign mismatch  = (o_user_data != cur_data);

    // Command outputs are zeroed when no command is requested, so reset and
    // idle present an all-zero bus. Address/data only change when k moves,
    // which only happens on accept, so they hold while ctrl_ready is low.
    assign write_enable        = (state == S_WRITE);
    assign read_enable         = (state == S_READ);
    assign i_user_data_address = (write_enable || read_enable) ? cur_addr : '0;
    assign i_user_data         = write_enable ? cur_data : '0;

    // Sequencer, read timeout down-counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            k                   <= '0;
            tmo_cnt             <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            timeout             <= 1'b0;
            error_count         <= '0;
            first_error_address <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state               <= S_WRITE;
                        k                   <= '0;
                        busy                <= 1'b1;
                        done                <= 1'b0;
                        pass                <= 1'b0;
                        timeout             <= 1'b0;
                        error_count         <= '0;
                        first_error_address <= '0;
                    end
                end
                S_WRITE: begin
                    if (ctrl_ready) begin
                        if (last_word) begin
                            state <= S_READ;
                            k     <= '0;
                        end else begin
                            k <= k + AW'(1);
                        end
                    end
                end
                S_READ: begin
                    if (ctrl_ready) begin
                        state   <= S_WAIT;
                        tmo_cnt <= TMO_LOAD;
                    end
                end
                S_WAIT: begin
                    if (o_user_data_valid) begin
                        if (mismatch) begin
                            if (error_count != 16'hFFFF) begin
                                error_count <= error_count + 16'd1;
                            end
                            if (error_count == 16'd0) begin
                                first_error_address <= cur_addr;
                            end
                        end
                        if (last_word) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (error_count == 16'd0);
                        end else begin
                            state <= S_READ;
                            k     <= k + AW'(1);
                        end
                    end else if (tmo_cnt == '0) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Bench for ddr3_traffic_checker: two instances (4 words from address 0,
// and 2 words from the all-ones address to exercise wrap), a behavioural
// memory that answers one read at a time, and a pass-level reference model.
module tb_ddr3_traffic_checker;

    localparam int AW  = 18;
    localparam int TMO = 40;
    localparam logic [15:0]   SEED  = 16'hA5C3;
    localparam logic [AW-1:0] ONES  = '1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic ctrl_ready = 1'b0;
    logic o_valid = 1'b0;
    logic [15:0] o_data = '0;

    logic we_a, re_a, busy_a, done_a, pass_a, to_a;
    logic we_b, re_b, busy_b, done_b, pass_b, to_b;
    logic [AW-1:0] addr_a, fea_a, addr_b, fea_b;
    logic [15:0] wd_a, ec_a, wd_b, ec_b;

    ddr3_traffic_checker #(.NUM_WORDS(4), .READ_TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ctrl_ready(ctrl_ready),
        .write_enable(we_a), .read_enable(re_a), .i_user_data_address(addr_a),
        .i_user_data(wd_a), .o_user_data(o_data), .o_user_data_valid(o_valid),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a),
        .error_count(ec_a), .first_error_address(fea_a));

    ddr3_traffic_checker #(.NUM_WORDS(2), .START_ADDRESS(ONES), .READ_TIMEOUT(TMO)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ctrl_ready(ctrl_ready),
        .write_enable(we_b), .read_enable(re_b), .i_user_data_address(addr_b),
        .i_user_data(wd_b), .o_user_data(o_data), .o_user_data_valid(o_valid),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b),
        .error_count(ec_b), .first_error_address(fea_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // active instance seen by the memory model
    logic sel = 1'b0;
    logic m_we, m_re, m_busy, m_done, m_pass, m_to;
    logic [AW-1:0] m_addr, m_fea;
    logic [15:0] m_wd, m_ec;
    assign m_we   = sel ? we_b   : we_a;
    assign m_re   = sel ? re_b   : re_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_pass = sel ? pass_b : pass_a;
    assign m_to   = sel ? to_b   : to_a;
    assign m_addr = sel ? addr_b : addr_a;
    assign m_fea  = sel ? fea_b  : fea_a;
    assign m_wd   = sel ? wd_b   : wd_a;
    assign m_ec   = sel ? ec_b   : ec_a;

    wire [73:0] outs_a = {we_a, re_a, busy_a, done_a, pass_a, to_a, addr_a, wd_a, ec_a, fea_a};
    wire [73:0] outs_b = {we_b, re_b, busy_b, done_b, pass_b, to_b, addr_b, wd_b, ec_b, fea_b};

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // memory model configuration
    int rdy_mode = 0;            // 0 always ready, 1 toggle, 2 random
    int lat = 3;
    bit no_resp = 1'b0;
    bit spur = 1'b0;
    bit corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [15:0] corrupt_mask = '0;

    logic [15:0]   mem [logic [AW-1:0]];
    logic [AW-1:0] wr_addr_q[$];
    logic [15:0]   wr_data_q[$];
    logic [AW-1:0] rd_addr_q[$];
    bit            resp_pending = 1'b0;
    int            resp_due = 0;
    logic [AW-1:0] resp_addr = '0;
    int            acc_edge = 0;
    bit            hold_v = 1'b0;
    logic [AW-1:0] hold_a = '0;
    logic [15:0]   hold_d = '0;

    // Memory model: drives ctrl_ready/read data mid-cycle, records accepted commands.
    initial forever begin
        @(negedge clk);
        if (hold_v && (m_we || m_re)) begin
            chk("hold_addr", 80'(m_addr), 80'(hold_a));
            if (m_we) chk("hold_data", 80'(m_wd), 80'(hold_d));
        end
        if (m_we || m_re) chk("we_re_excl", 80'(m_we & m_re), 80'(0));

        case (rdy_mode)
            0:       ctrl_ready = 1'b1;
            1:       ctrl_ready = ~ctrl_ready;
            default: ctrl_ready = ($urandom_range(0, 99) < 60);
        endcase
        hold_v = (m_we || m_re) && !ctrl_ready;
        hold_a = m_addr;
        hold_d = m_wd;

        o_valid = 1'b0;
        o_data  = 16'($urandom);
        if (resp_pending && cyc == resp_due) begin
            o_valid = 1'b1;
            o_data  = mem[resp_addr] ^ ((corrupt_en && resp_addr == corrupt_addr) ? corrupt_mask : 16'h0);
            resp_pending = 1'b0;
        end else if (spur && !no_resp && !resp_pending && $urandom_range(0, 3) == 0) begin
            o_valid = 1'b1;
        end

        if (reset) begin
            resp_pending = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (m_we && ctrl_ready) begin
                mem[m_addr] = m_wd;
                wr_addr_q.push_back(m_addr);
                wr_data_q.push_back(m_wd);
            end
            if (m_re && ctrl_ready) begin
                rd_addr_q.push_back(m_addr);
                acc_edge = cyc + 1;
                if (!no_resp) begin
                    resp_pending = 1'b1;
                    resp_due = cyc + lat;
                    resp_addr = m_addr;
                end
            end
        end
    end

    task automatic setup(input bit s, input int mode, input int l, input bit ce,
                         input logic [AW-1:0] ca, input logic [15:0] cm, input bit nr, input bit sp);
        sel = s; rdy_mode = mode; lat = l; corrupt_en = ce; corrupt_addr = ca;
        corrupt_mask = cm; no_resp = nr; spur = sp;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        resp_pending = 1'b0; hold_v = 1'b0; acc_edge = 0;
    endtask

    // Run one pass and compare against the expected write/read sequences and results.
    task automatic run_pass(input string tag, input bit s, input int n, input logic [AW-1:0] sa,
                            input int mode, input int l, input bit ce, input logic [AW-1:0] ca,
                            input logic [15:0] cm, input bit nr, input bit sp);
        int waited;
        int done_cyc;
        int exp_err;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] a;
        logic [15:0] d;
        setup(s, mode, l, ce, ca, cm, nr, sp);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        chk({tag, "_busy"}, 80'(m_busy), 80'(1));
        chk({tag, "_done_clr"}, 80'(m_done), 80'(0));
        waited = 0;
        while (!m_done && waited < 3000) begin
            if (sp && m_busy && $urandom_range(0, 7) == 0) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            tick();
            start_a = 1'b0; start_b = 1'b0;
            waited++;
        end
        done_cyc = cyc;
        chk({tag, "_done"}, 80'(m_done), 80'(1));

        exp_err = 0;
        exp_first = '0;
        chk({tag, "_wr_count"}, 80'(wr_addr_q.size()), 80'(n));
        for (int k = 0; k < n; k++) begin
            a = sa + AW'(k);
            d = SEED ^ 16'(k);
            if (k < wr_addr_q.size()) begin
                chk({tag, "_wr_addr"}, 80'(wr_addr_q[k]), 80'(a));
                chk({tag, "_wr_data"}, 80'(wr_data_q[k]), 80'(d));
            end
            if (!nr) begin
                if (k < rd_addr_q.size()) chk({tag, "_rd_addr"}, 80'(rd_addr_q[k]), 80'(a));
                if (ce && a == ca && cm != 16'h0) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end
        end
        if (nr) begin
            chk({tag, "_rd_count"}, 80'(rd_addr_q.size()), 80'(1));
            chk({tag, "_tmo_latency"}, 80'(done_cyc - acc_edge), 80'(TMO + 1));
        end else begin
            chk({tag, "_rd_count"}, 80'(rd_addr_q.size()), 80'(n));
        end
        chk({tag, "_timeout"}, 80'(m_to), 80'(nr));
        chk({tag, "_err_count"}, 80'(m_ec), 80'(exp_err));
        chk({tag, "_first_err"}, 80'(m_fea), 80'(exp_first));
        chk({tag, "_pass"}, 80'(m_pass), 80'(exp_err == 0 && !nr));
        chk({tag, "_busy_end"}, 80'(m_busy), 80'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized passes.
    initial begin
        int waited;
        repeat (3) tick();
        chk("reset_outs_a", 80'(outs_a), 80'(0));
        chk("reset_outs_b", 80'(outs_b), 80'(0));
        reset = 1'b0;
        tick();

        run_pass("basic",   1'b0, 4, '0, 0, 3, 1'b0, '0,      16'h0, 1'b0, 1'b0);
        run_pass("corrupt", 1'b0, 4, '0, 0, 3, 1'b1, AW'(2),  16'h1, 1'b0, 1'b0);
        run_pass("toggle",  1'b0, 4, '0, 1, 3, 1'b0, '0,      16'h0, 1'b0, 1'b0);
        run_pass("tmo",     1'b0, 4, '0, 0, 3, 1'b0, '0,      16'h0, 1'b1, 1'b0);

        // reset while writing word 2
        setup(1'b0, 0, 3, 1'b0, '0, 16'h0, 1'b0, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        waited = 0;
        while (!(we_a && addr_a == AW'(2)) && waited < 50) begin
            tick();
            waited++;
        end
        chk("rst_mid_reached", 80'({we_a, addr_a}), 80'({1'b1, AW'(2)}));
        reset = 1'b1;
        tick();
        chk("rst_mid_outs", 80'(outs_a), 80'(0));
        reset = 1'b0;
        tick();
        run_pass("after_rst", 1'b0, 4, '0, 0, 3, 1'b0, '0, 16'h0, 1'b0, 1'b0);

        run_pass("wrap",      1'b1, 2, ONES, 0, 3, 1'b0, '0, 16'h0, 1'b0, 1'b0);
        run_pass("wrap_corr", 1'b1, 2, ONES, 2, 2, 1'b1, '0, 16'h8000, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_pass("rand", 1'b0, 4, '0, 2, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)), 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
